// File: rtl/atari_pot_scan.sv
// POKEY-style paddle scanner: maps signed axis values to pot counts 1..228 and
// replays the POT0..POTn counters and ALLPOT status after each POTGO strobe.
module atari_pot_scan #(
  parameter int NUM_POTS = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ENABLE_179,
  input  logic                    LINE_STB,
  input  logic                    FAST_SCAN,
  input  logic                    POTGO,
  input  logic [NUM_POTS-1:0]     POT_CONNECTED,
  input  logic [8*NUM_POTS-1:0]   AXIS,
  output logic [8*NUM_POTS-1:0]   POT_OUT,
  output logic [NUM_POTS-1:0]     ALLPOT,
  output logic                    SCAN_BUSY
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;
  localparam logic [7:0] POT_MAX     = 8'd228;

  logic [1:0]          state_q, state_d;
  logic [7:0]          cnt_q    [NUM_POTS];
  logic [7:0]          cnt_d    [NUM_POTS];
  logic [7:0]          target_q [NUM_POTS];
  logic [7:0]          target_d [NUM_POTS];
  logic [NUM_POTS-1:0] allpot_q, allpot_d;
  logic                busy_q, busy_d;

  logic [15:0]         product    [NUM_POTS];
  logic [7:0]          target_map [NUM_POTS];
  logic [7:0]          cnt_inc    [NUM_POTS];
  logic                tick;

  // Flipping the sign bit turns the signed axis into its offset-binary 0..255 form.
  always_comb begin
    for (int i = 0; i < NUM_POTS; i++) begin
      product[i]    = {8'd0, AXIS[8*i +: 8] ^ 8'h80} * 16'd228;
      target_map[i] = POT_CONNECTED[i] ? (product[i][15:8] + 8'd1) : POT_MAX;
    end
  end

  assign tick = FAST_SCAN ? ENABLE_179 : LINE_STB;

  always_comb begin
    state_d  = state_q;
    allpot_d = allpot_q;
    busy_d   = |allpot_q;
    for (int i = 0; i < NUM_POTS; i++) begin
      cnt_d[i]    = cnt_q[i];
      target_d[i] = target_q[i];
      cnt_inc[i]  = cnt_q[i] + 8'd1;
    end

    if (POTGO) begin
      state_d  = ST_SCAN;
      allpot_d = '1;
      busy_d   = 1'b1;
      for (int i = 0; i < NUM_POTS; i++) begin
        cnt_d[i]    = 8'd0;
        target_d[i] = target_map[i];
      end
    end else if (state_q == ST_SCAN) begin
      if (allpot_q == '0) begin
        state_d = ST_COMPLETE;
      end else if (tick) begin
        for (int i = 0; i < NUM_POTS; i++) begin
          if (allpot_q[i]) begin
            // The 228 ceiling ends a pot even when its captured target is unreachable.
            if (cnt_q[i] >= POT_MAX) begin
              allpot_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_inc[i];
              if (cnt_inc[i] == target_q[i] || cnt_inc[i] == POT_MAX) begin
                allpot_d[i] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      allpot_q <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) begin
        cnt_q[i]    <= 8'd0;
        target_q[i] <= 8'd0;
      end
    end else begin
      state_q  <= state_d;
      allpot_q <= allpot_d;
      busy_q   <= busy_d;
      for (int i = 0; i < NUM_POTS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        target_q[i] <= target_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_POTS; i++) begin
      POT_OUT[8*i +: 8] = cnt_q[i];
    end
  end

  assign ALLPOT    = allpot_q;
  assign SCAN_BUSY = busy_q;

endmodule

// File: tb/tb_atari_pot_scan.sv
// Directed bench for atari_pot_scan: hand-computed pot counts, ALLPOT timing,
// slow/fast tick selection, POTGO collisions and asynchronous reset.
module tb_atari_pot_scan;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ENABLE_179;
  logic        LINE_STB;
  logic        FAST_SCAN;
  logic        POTGO;
  logic [3:0]  POT_CONNECTED;
  logic [31:0] AXIS;
  logic [31:0] POT_OUT;
  logic [3:0]  ALLPOT;
  logic        SCAN_BUSY;

  int checkCount = 0;
  int passCount  = 0;

  atari_pot_scan #(.NUM_POTS(4)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .ENABLE_179    (ENABLE_179),
    .LINE_STB      (LINE_STB),
    .FAST_SCAN     (FAST_SCAN),
    .POTGO         (POTGO),
    .POT_CONNECTED (POT_CONNECTED),
    .AXIS          (AXIS),
    .POT_OUT       (POT_OUT),
    .ALLPOT        (ALLPOT),
    .SCAN_BUSY     (SCAN_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic potgo, input logic en, input logic line);
    POTGO      = potgo;
    ENABLE_179 = en;
    LINE_STB   = line;
    @(posedge CLK);
    #1;
    POTGO      = 1'b0;
    ENABLE_179 = 1'b0;
    LINE_STB   = 1'b0;
  endtask

  int          tgt [4];
  logic [31:0] expPot;
  logic [3:0]  expAll;

  initial begin
    RESET_N       = 1'b0;
    ENABLE_179    = 1'b0;
    LINE_STB      = 1'b0;
    FAST_SCAN     = 1'b1;
    POTGO         = 1'b0;
    POT_CONNECTED = 4'b1111;
    AXIS          = 32'h0;
    #3;
    checkOutput("reset_pot", POT_OUT, 32'h0);
    checkOutput("reset_allpot", {28'h0, ALLPOT}, 32'h0);
    checkOutput("reset_busy", {31'h0, SCAN_BUSY}, 32'h0);
    #9 RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Centre and extremes: pot0=0, pot1=-128, pot2=127, pot3=-64.
    AXIS = {8'hC0, 8'h7F, 8'h80, 8'h00};
    tgt  = '{115, 1, 228, 58};
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("potgo_pot", POT_OUT, 32'h0);
    checkOutput("potgo_allpot", {28'h0, ALLPOT}, 32'hF);
    checkOutput("potgo_busy", {31'h0, SCAN_BUSY}, 32'h1);
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
        expPot[8*i +: 8] = 8'((k < tgt[i]) ? k : tgt[i]);
        expAll[i]        = (k < tgt[i]);
      end
      checkOutput($sformatf("t1_pot_k%0d", k), POT_OUT, expPot);
      checkOutput($sformatf("t1_allpot_k%0d", k), {28'h0, ALLPOT}, {28'h0, expAll});
      checkOutput($sformatf("t1_busy_k%0d", k), {31'h0, SCAN_BUSY}, {31'h0, (k <= 228)});
    end
    checkOutput("t1_final", POT_OUT, {8'd58, 8'd228, 8'd1, 8'd115});

    // Post-complete ticks must not disturb anything.
    for (int k = 0; k < 100; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("post_pot", POT_OUT, {8'd58, 8'd228, 8'd1, 8'd115});
    checkOutput("post_allpot", {28'h0, ALLPOT}, 32'h0);
    checkOutput("post_busy", {31'h0, SCAN_BUSY}, 32'h0);

    // Disconnected pot0 with a -128 axis still runs to 228.
    POT_CONNECTED = 4'b1110;
    AXIS          = {8'h00, 8'h00, 8'h00, 8'h80};
    applyStimulus(1'b1, 1'b0, 1'b0);
    POT_CONNECTED = 4'b1111;
    for (int k = 1; k <= 228; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 1 || k == 227 || k == 228) begin
        checkOutput($sformatf("disc_pot0_k%0d", k), {24'h0, POT_OUT[7:0]}, k);
        checkOutput($sformatf("disc_all0_k%0d", k), {31'h0, ALLPOT[0]}, {31'h0, (k < 228)});
      end
    end

    // Slow scan: only LINE_STB advances the counters.
    FAST_SCAN = 1'b0;
    AXIS      = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("slow_en_only", {24'h0, POT_OUT[7:0]}, 32'd0);
    for (int k = 1; k <= 115; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 114) checkOutput("slow_all0_k114", {31'h0, ALLPOT[0]}, 32'h1);
    end
    checkOutput("slow_pot0", {24'h0, POT_OUT[7:0]}, 32'd115);
    checkOutput("slow_all0", {31'h0, ALLPOT[0]}, 32'h0);
    FAST_SCAN = 1'b1;

    // POTGO colliding with tick 50 restarts; a mid-scan axis change is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 50; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("coll_pre_pot0", {24'h0, POT_OUT[7:0]}, 32'd49);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("coll_pot", POT_OUT, 32'h0);
    checkOutput("coll_allpot", {28'h0, ALLPOT}, 32'hF);
    for (int k = 1; k <= 115; k++) begin
      if (k == 60) AXIS[7:0] = 8'h7F;
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 114) checkOutput("axchg_all0_k114", {31'h0, ALLPOT[0]}, 32'h1);
    end
    checkOutput("axchg_pot0", {24'h0, POT_OUT[7:0]}, 32'd115);
    checkOutput("axchg_all0", {31'h0, ALLPOT[0]}, 32'h0);

    // Asynchronous reset at tick 30.
    AXIS = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_pre_pot0", {24'h0, POT_OUT[7:0]}, 32'd30);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("rst_pot", POT_OUT, 32'h0);
    checkOutput("rst_allpot", {28'h0, ALLPOT}, 32'h0);
    checkOutput("rst_busy", {31'h0, SCAN_BUSY}, 32'h0);
    #2 RESET_N = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rst_idle_pot", POT_OUT, 32'h0);
    checkOutput("rst_idle_allpot", {28'h0, ALLPOT}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/atari_pot_scan.md
# atari_pot_scan

Paddle/analog-axis scanner that emulates POKEY POT0..POTn counters and the ALLPOT status for the Atari 5200 core. It consumes the signed 8-bit analog axis values delivered to the core's JOYnX/JOYnY inputs, whether they come from a real analog stick or from the mouse-to-axis emulation. It converts each value to a POKEY pot count of 1..228 and reproduces the counter's time-based behaviour after each POTGO strobe from the POKEY register interface.

## Interface
- NUM_POTS, default 4: number of pot channels. The 5200 uses two controllers with an X and a Y axis each.
- CLK  in  1  system clock (clk_sys domain).
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE_179  in  1  one-cycle strobe at the 1.79 MHz CPU rate.
- LINE_STB  in  1  one-cycle strobe once per scanline (15.7 kHz).
- FAST_SCAN  in  1  SKCTL bit 2. 1 selects fast scan, which ticks on ENABLE_179; 0 ticks on LINE_STB.
- POTGO  in  1  one-cycle strobe from a POTGO register write.
- POT_CONNECTED  in  NUM_POTS  per-pot controller-present flag.
- AXIS  in  8*NUM_POTS  signed two's-complement axis. Pot i occupies [8i+7:8i].
- POT_OUT  out  8*NUM_POTS  current pot counter. Pot i occupies [8i+7:8i].
- ALLPOT  out  NUM_POTS  bit i = 1 while pot i is still counting.
- SCAN_BUSY  out  1  1 while any ALLPOT bit is 1.

## Operation
- **Target mapping.**
  - u = AXIS_i + 128, unsigned 8-bit, range 0..255.
  - target_i = ((u × 228) >> 8) + 1, range 1..228. Use a 16-bit product and no division.
  - If POT_CONNECTED[i] = 0, target_i = 228.
- **Target capture.** target_i is captured into a register on POTGO. AXIS and POT_CONNECTED changes during a scan are ignored until the next POTGO.
- **Global FSM.** States are IDLE, SCAN and COMPLETE.
  - IDLE → SCAN on POTGO.
  - SCAN → COMPLETE when every ALLPOT bit is 0.
  - COMPLETE → SCAN on POTGO.
  - POTGO in SCAN restarts the scan.
- **Tick.** tick = FAST_SCAN ? ENABLE_179 : LINE_STB. FAST_SCAN is sampled every cycle, so a mode change takes effect on the next tick.
- **Per-pot behaviour, in SCAN, on a tick:**
  - If ALLPOT[i] = 1: POT_OUT_i ← POT_OUT_i + 1.
  - If POT_OUT_i + 1 == target_i: ALLPOT[i] ← 0 in the same cycle.
  - A pot with ALLPOT[i] = 0 holds its value.
  - The counter never exceeds 228. At 228 ALLPOT[i] clears unconditionally, even if target_i is corrupt.
- **Simultaneous events.**
  - POTGO in the same cycle as a tick: POTGO wins. Counters go to 0 and the tick is discarded.
  - Ticks are ignored in IDLE and COMPLETE.

## Timing
- **Reset values:**
  - POT_OUT = all 0.
  - ALLPOT = 0.
  - SCAN_BUSY = 0.
  - FSM = IDLE.
  - targets = 0.
- **Reset mid-scan:** all outputs return to their reset values asynchronously. Behaviour resumes only on a new POTGO.
- **POTGO latency:** POTGO high in cycle n gives POT_OUT = 0, ALLPOT = all 1s and SCAN_BUSY = 1, visible at cycle n+1.
- **Tick latency:** a tick in cycle n updates POT_OUT and ALLPOT, visible at cycle n+1.
- **Counting time:** a pot with target t is done after exactly t ticks following POTGO. Its final POT_OUT = t.
- **SCAN_BUSY** is registered and falls in the cycle after the last ALLPOT bit falls.
- **Mapping path:** may be registered. If so, target capture must use the value from the cycle of POTGO with zero extra latency; pre-register the mapped target every cycle.

## Test plan
- **Centre and extremes.** AXIS = {0, −128, 127, −64}, all connected, FAST_SCAN = 1, POTGO, then 300 ENABLE_179 strobes.
  - Final POT_OUT = {115, 1, 228, 58}.
  - ALLPOT bits clear after exactly 115, 1, 228 and 58 ticks.
  - SCAN_BUSY falls after tick 228 plus 1 cycle.
- **Disconnected pot.** POT_CONNECTED = 4'b1110, AXIS0 = −128, POTGO.
  - POT_OUT0 ends at 228, not 1.
  - ALLPOT[0] clears at tick 228.
- **Slow scan.** FAST_SCAN = 0, AXIS0 = 0, POTGO.
  - ENABLE_179 strobes alone do not change POT_OUT0.
  - After 115 LINE_STB pulses, POT_OUT0 = 115 and ALLPOT[0] = 0.
- **Restart and collision.**
  - At tick 50 of a scan, assert POTGO in the same cycle as a tick. Next cycle: POT_OUT = 0 and ALLPOT = 4'b1111.
  - Change AXIS0 mid-scan from 0 to 127. The scan still ends at 115.
- **Reset mid-scan.** Deassert RESET_N at tick 30.
  - All outputs are 0 immediately, and the FSM is IDLE.
  - Further ticks without POTGO leave POT_OUT = 0.
- **Post-complete ticks.** After COMPLETE, apply 100 more ticks. POT_OUT and ALLPOT are unchanged.
